// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 2:1 datapath mux.
// Optional build switch: MUX2_ARB_FIXED_PRIO_EN selects fixed priority for requester 0.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out1,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic             out_valid_q, out_valid_d;

  // tie_to_1: requester 1 wins an IDLE tie; preempt0: GRANT0 may be forced off at MAX_HOLD.
  logic tie_to_1;
  logic preempt0;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  assign tie_to_1 = 1'b0;
  assign preempt0 = 1'b0;
`else
  logic last_owner_q, last_owner_d;

  assign tie_to_1 = ~last_owner_q;
  assign preempt0 = 1'b1;
`endif

  // NOTE: every variable gets a default before the case logic so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    sel_d       = sel_q;
    out1_d      = out1_q;
    out_valid_d = 1'b0;

    if (state_q == GRANT0 && req0) begin
      out1_d      = In0;
      out_valid_d = 1'b1;
    end else if (state_q == GRANT1 && req1) begin
      out1_d      = In1;
      out_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = tie_to_1 ? GRANT1 : GRANT0;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0: begin
        if (!req0)                                        state_d = req1 ? GRANT1 : IDLE;
        else if (req1 && preempt0 && hold_q == MAX_HOLD_C) state_d = GRANT1;
      end
      GRANT1: begin
        if (!req1)                             state_d = req0 ? GRANT0 : IDLE;
        else if (req0 && hold_q == MAX_HOLD_C) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts at 1 on each new owner and saturates while the owner is kept.
    if (state_d == IDLE)           hold_d = 4'd0;
    else if (state_d != state_q)   hold_d = 4'd1;
    else if (hold_q < MAX_HOLD_C)  hold_d = hold_q + 4'd1;

    if (state_d == GRANT0)      sel_d = 1'b0;
    else if (state_d == GRANT1) sel_d = 1'b1;
  end

`ifndef MUX2_ARB_FIXED_PRIO_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d != state_q && state_d != IDLE) last_owner_d = (state_d == GRANT1);
  end

  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= 1'b1;
    else     last_owner_q <= last_owner_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= 4'd0;
      sel_q       <= 1'b0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sel_q       <= sel_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt0      = (state_q == GRANT0);
  assign gnt1      = (state_q == GRANT1);
  assign sel       = sel_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a requester-level model predicts each cycle's outputs.
module tb_mux2_rr_arbiter;

  localparam int WIDTH    = 3;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] In0, In1;
  logic             gnt0, gnt1, sel, out_valid;
  logic [WIDTH-1:0] out1;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .In0(In0), .In1(In1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out1(out1), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             g0;
    logic             g1;
    logic             s;
    logic             v;
    logic [WIDTH-1:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: who owns the bus (-1 = nobody), how long they have held it, who owned it last.
  int               owner;
  int               run_len;
  int               last;
  logic             sel_m;
  logic             valid_m;
  logic [WIDTH-1:0] out_m;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic r0, input logic r1,
                            input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    logic             req [2];
    logic [WIDTH-1:0] dat [2];
    int               nxt;
    req[0] = r0; req[1] = r1; dat[0] = d0; dat[1] = d1;
    if (r) begin
      owner = -1; run_len = 0; last = 1; sel_m = 1'b0; out_m = '0; valid_m = 1'b0;
      return;
    end
    valid_m = (owner >= 0) && req[owner];
    if (valid_m) out_m = dat[owner];
    if (owner < 0) begin
      if (r0 && r1)  nxt = FIXED ? 0 : 1 - last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else if (!req[owner]) begin
      nxt = req[1 - owner] ? 1 - owner : -1;
    end else if (req[1 - owner] && run_len >= MAX_HOLD && !(FIXED && owner == 0)) begin
      nxt = 1 - owner;
    end else begin
      nxt = owner;
    end
    if (nxt < 0)             run_len = 0;
    else if (nxt != owner) begin
      run_len = 1;
      last    = nxt;
    end else if (run_len < MAX_HOLD) run_len = run_len + 1;
    owner = nxt;
    if (owner >= 0) sel_m = (owner == 1);
  endtask

  // Apply one cycle of inputs; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic r, input logic r0, input logic r1,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    exp_t e;
    rst = r; req0 = r0; req1 = r1; In0 = d0; In1 = d1;
    model_step(r, r0, r1, d0, d1);
    e.g0 = (owner == 0); e.g1 = (owner == 1); e.s = sel_m; e.v = valid_m; e.o = out_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt0",      32'(gnt0),      32'(e.g0));
      check("gnt1",      32'(gnt1),      32'(e.g1));
      check("sel",       32'(sel),       32'(e.s));
      check("out_valid", 32'(out_valid), 32'(e.v));
      check("out1",      32'(out1),      32'(e.o));
    end
  end

  initial begin
    logic r0, r1;
    owner = -1; run_len = 0; last = 1; sel_m = 1'b0; out_m = '0; valid_m = 1'b0;

    // Reset held with both requesting, then release: requester 0 wins first.
    step(1, 1, 1, 3'b000, 3'b000);
    step(1, 1, 1, 3'b000, 3'b000);
    step(0, 1, 1, 3'b001, 3'b110);
    step(0, 0, 0, 3'b000, 3'b000);
    step(0, 0, 0, 3'b000, 3'b000);
    step(0, 0, 0, 3'b000, 3'b000);

    // Single requester for three cycles, then idle.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'b101, 3'b000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 3'b000, 3'b000);

    // Fairness under continuous contention.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 3'b001, 3'b110);
    for (int i = 0; i < 2; i++)  step(0, 0, 0, 3'b000, 3'b000);

    // Handover without an IDLE bubble.
    for (int i = 0; i < 2; i++) step(0, 1, 0, 3'b011, 3'b100);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'b011, 3'b100);
    step(0, 0, 0, 3'b000, 3'b000);

    // Reset mid-transfer in GRANT1, then both request.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'b010, 3'b111);
    step(1, 1, 1, 3'b010, 3'b111);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 3'b010, 3'b111);

    // Randomized traffic with sticky requests and occasional reset.
    r0 = 1'b0; r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      step(($urandom_range(63) == 0), r0, r1, WIDTH'($urandom), WIDTH'($urandom));
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
